mole_game_ctrl: RTL and testbench
=================================

Name: mole_game_ctrl

Overview:
- Parametrised successor to the three-round game controller. It sequences N configurable rounds of whack-a-mole and derives each round's interval, duration and mole count arithmetically from the level.
- Adds a lives/retry mechanism, pause, a saturating cumulative score and distinct win/lose terminal states.
- Drives the existing round engine through a start/done handshake and feeds the score/level display logic.

Parameters:
NUM_ROUNDS, 3, number of levels to win (1..7)
PASS_HITS, 3, hits in a round required to advance
MAX_LIVES, 2, failed rounds tolerated before loss (1..7)
TIMER_W, 27, width of interval/duration words
MOLE_W, 3, width of mole count
SCORE_W, 8, width of total score
BASE_INTERVAL, 125000000, level-0 interval in clocks
STEP_INTERVAL, 25000000, interval decrement per level
MIN_INTERVAL, 25000000, interval floor
BASE_DURATION, 100000000, level-0 duration in clocks
STEP_DURATION, 25000000, duration decrement per level
MIN_DURATION, 12500000, duration floor
BASE_MOLES, 4, level-0 mole count
STEP_MOLES, 1, mole increment per level

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
game_start  in  1  start/restart request, level-sensitive
pause  in  1  pause request, level-sensitive
hit_success  in  1  one-cycle pulse per valid hit from round engine
round_done  in  1  one-cycle pulse when round engine finishes its round
round_start  out  1  one-cycle pulse launching a round
interval  out  TIMER_W  registered per-round interval
duration  out  TIMER_W  registered per-round duration
molenum  out  MOLE_W  registered per-round mole count
round_hold  out  1  high while paused; round engine freezes timers
round_level  out  3  current level, 0-based
round_hits  out  3  hits in current round, saturating at 7
total_score  out  SCORE_W  cumulative hits, saturating
lives  out  3  remaining lives
game_win  out  1  high in WIN
game_over  out  1  high in WIN or LOSE
high_score  out  SCORE_W  see Optional Feature

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, except lives=MAX_LIVES.
- States: IDLE, CONFIG, LAUNCH, RUNNING, PAUSED, EVAL, WIN, LOSE.
- IDLE: on game_start go to CONFIG; clear round_level, total_score and round_hits; lives=MAX_LIVES.
- CONFIG (1 cycle): register the level config.
  - interval = max(BASE_INTERVAL - L*STEP_INTERVAL, MIN_INTERVAL).
  - duration = max(BASE_DURATION - L*STEP_DURATION, MIN_DURATION).
  - molenum = min(BASE_MOLES + L*STEP_MOLES, 2^MOLE_W-1).
  - Subtraction is computed at TIMER_W+1 bits and underflow clamps to the floor.
  - Clear round_hits. Next state LAUNCH.
- LAUNCH (1 cycle): round_start=1, so round_start rises exactly 2 cycles after CONFIG entry. Config outputs are stable from CONFIG+1 until the next CONFIG. Next state RUNNING.
- RUNNING:
  - hit_success increments round_hits (sat 7) and total_score (sat 2^SCORE_W-1).
  - round_done goes to EVAL; this has priority over pause.
  - pause=1 with no round_done goes to PAUSED.
- PAUSED: round_hold=1. hit_success is ignored, and round_done is latched and acted on at resume. pause=0 returns to RUNNING, or to EVAL if round_done was latched.
- A hit_success coincident with round_done is counted before EVAL.
- EVAL (1 cycle):
  - round_hits>=PASS_HITS:
    - if round_level==NUM_ROUNDS-1 go to WIN;
    - else round_level+1, go to CONFIG.
  - round_hits<PASS_HITS:
    - lives-1;
    - if the new lives==0 go to LOSE;
    - else go to CONFIG at the same level (retry).
- WIN/LOSE: hold all counters; game_over=1, game_win=1 only in WIN. game_start returns to CONFIG with counters re-initialised as in IDLE.
- Reset mid-round forces IDLE immediately. No round_start is issued until a new game_start.
- round_done outside RUNNING/PAUSED is ignored.
- All outputs are registered; no combinational input-to-output path.

Optional Feature:
HIGH_SCORE_EN
- Defined: high_score register updates to total_score on entry to WIN or LOSE when total_score > high_score. It is cleared only by rst and survives restarts.
- Undefined: high_score is constant 0 and no register is inferred.

Decomposition:
- Package mole_game_pkg holds the state enumeration (3-bit localparams) and the saturating-add width helpers.
- One sub-module, mole_level_cfg: purely combinational level-to-{interval, duration, molenum} with clamping, registered by the parent in CONFIG.

Test Plan:
- Defaults, game_start, 3 hit_success per round, round_done each round -> configs (125M,100M,4), (100M,75M,5), (75M,50M,6); game_win=1, total_score=9.
- Level 0 round with 2 hits -> lives 2->1, round_level stays 0, round_start re-pulses with same config; repeat failure -> LOSE, game_over=1, game_win=0.
- STEP_INTERVAL=60M, NUM_ROUNDS=4 -> level 2 interval clamps to 25M (MIN_INTERVAL); molenum clamps to 7 with BASE_MOLES=6.
- pause during RUNNING, then round_done and hit_success while paused -> round_hold=1, hit ignored; on release EVAL is entered within 1 cycle.
- rst low mid-RUNNING -> immediate IDLE, all outputs 0, lives=2; no round_start without game_start.
- HIGH_SCORE_EN: game 1 score 9, game 2 score 5 -> high_score stays 9; without the macro -> high_score=0.

Source files
------------

// File: rtl/mole_game_pkg.sv
// Shared definitions for the whack-a-mole game controller.
//   state_e       : controller state enumeration (3-bit encoding)
//   LVL_W/HITS_W/LIVES_W : widths of level, round-hit and lives counters
//   sat_inc_hits  : saturating increment for the round-hit counter
package mole_game_pkg;

  localparam int unsigned LVL_W   = 3;
  localparam int unsigned HITS_W  = 3;
  localparam int unsigned LIVES_W = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_LAUNCH  = 3'd2,
    S_RUNNING = 3'd3,
    S_PAUSED  = 3'd4,
    S_EVAL    = 3'd5,
    S_WIN     = 3'd6,
    S_LOSE    = 3'd7
  } state_e;

  function automatic logic [HITS_W-1:0] sat_inc_hits(input logic [HITS_W-1:0] v);
    return (v == '1) ? v : v + HITS_W'(1);
  endfunction

endpackage

// File: rtl/mole_level_cfg.sv
// Combinational level-to-round-configuration mapping.
//   level    : 0-based game level
//   interval : max(BASE_INTERVAL - level*STEP_INTERVAL, MIN_INTERVAL)
//   duration : max(BASE_DURATION - level*STEP_DURATION, MIN_DURATION)
//   molenum  : min(BASE_MOLES + level*STEP_MOLES, 2^MOLE_W-1)
// The subtraction is done one bit wider than TIMER_W; any underflow
// clamps to the floor value.
module mole_level_cfg #(
  parameter int unsigned TIMER_W       = 27,
  parameter int unsigned MOLE_W        = 3,
  parameter int unsigned BASE_INTERVAL = 125000000,
  parameter int unsigned STEP_INTERVAL = 25000000,
  parameter int unsigned MIN_INTERVAL  = 25000000,
  parameter int unsigned BASE_DURATION = 100000000,
  parameter int unsigned STEP_DURATION = 25000000,
  parameter int unsigned MIN_DURATION  = 12500000,
  parameter int unsigned BASE_MOLES    = 4,
  parameter int unsigned STEP_MOLES    = 1
) (
  input  logic [2:0]         level,
  output logic [TIMER_W-1:0] interval,
  output logic [TIMER_W-1:0] duration,
  output logic [MOLE_W-1:0]  molenum
);

  // Product width: level is 3 bits, so level*step needs 3 extra bits.
  localparam int unsigned PW = TIMER_W + 4;

  localparam logic [TIMER_W:0]   BASE_IV  = (TIMER_W+1)'(BASE_INTERVAL);
  localparam logic [PW-1:0]      STEP_IV  = PW'(STEP_INTERVAL);
  localparam logic [TIMER_W-1:0] FLOOR_IV = TIMER_W'(MIN_INTERVAL);
  localparam logic [TIMER_W:0]   BASE_DU  = (TIMER_W+1)'(BASE_DURATION);
  localparam logic [PW-1:0]      STEP_DU  = PW'(STEP_DURATION);
  localparam logic [TIMER_W-1:0] FLOOR_DU = TIMER_W'(MIN_DURATION);
  localparam int unsigned        MOLE_MAX = (1 << MOLE_W) - 1;

  function automatic logic [TIMER_W-1:0] clamp_step(
    input logic [2:0]         lvl,
    input logic [TIMER_W:0]   base,
    input logic [PW-1:0]      step,
    input logic [TIMER_W-1:0] floor_v
  );
    logic [PW-1:0]    prod;
    logic [TIMER_W:0] diff;
    prod = PW'(lvl) * step;
    diff = base - prod[TIMER_W:0];
    // prod > base catches underflow even when the product exceeds TIMER_W+1 bits
    if ((prod > PW'(base)) || (diff < {1'b0, floor_v})) begin
      return floor_v;
    end
    return diff[TIMER_W-1:0];
  endfunction

  logic [31:0] mole_sum;

  always_comb begin
    interval = clamp_step(level, BASE_IV, STEP_IV, FLOOR_IV);
    duration = clamp_step(level, BASE_DU, STEP_DU, FLOOR_DU);
    mole_sum = BASE_MOLES + 32'(level) * STEP_MOLES;
    molenum  = (mole_sum > MOLE_MAX) ? MOLE_W'(MOLE_MAX) : mole_sum[MOLE_W-1:0];
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: runs NUM_ROUNDS levels through the round
// engine via a round_start/round_done handshake, with lives/retry, pause,
// saturating score and win/lose terminal states.
// Ports:
//   clk, rst (async active-low)
//   game_start, pause        : level-sensitive requests
//   hit_success, round_done  : pulses from the round engine
//   round_start              : one-cycle launch pulse
//   interval/duration/molenum: registered per-round configuration
//   round_hold               : high while paused
//   round_level/round_hits/total_score/lives : game counters
//   game_win/game_over       : terminal status
//   high_score               : best score (only with HIGH_SCORE_EN)
// Build option: define HIGH_SCORE_EN to enable the high_score register;
// otherwise high_score is tied to zero.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS    = 3,
  parameter int unsigned PASS_HITS     = 3,
  parameter int unsigned MAX_LIVES     = 2,
  parameter int unsigned TIMER_W       = 27,
  parameter int unsigned MOLE_W        = 3,
  parameter int unsigned SCORE_W       = 8,
  parameter int unsigned BASE_INTERVAL = 125000000,
  parameter int unsigned STEP_INTERVAL = 25000000,
  parameter int unsigned MIN_INTERVAL  = 25000000,
  parameter int unsigned BASE_DURATION = 100000000,
  parameter int unsigned STEP_DURATION = 25000000,
  parameter int unsigned MIN_DURATION  = 12500000,
  parameter int unsigned BASE_MOLES    = 4,
  parameter int unsigned STEP_MOLES    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               pause,
  input  logic               hit_success,
  input  logic               round_done,
  output logic               round_start,
  output logic [TIMER_W-1:0] interval,
  output logic [TIMER_W-1:0] duration,
  output logic [MOLE_W-1:0]  molenum,
  output logic               round_hold,
  output logic [2:0]         round_level,
  output logic [2:0]         round_hits,
  output logic [SCORE_W-1:0] total_score,
  output logic [2:0]         lives,
  output logic               game_win,
  output logic               game_over,
  output logic [SCORE_W-1:0] high_score
);

  localparam logic [LVL_W-1:0]   LAST_LVL   = LVL_W'(NUM_ROUNDS - 1);
  localparam logic [HITS_W-1:0]  PASS_C     = HITS_W'(PASS_HITS);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   interval_q, interval_d;
  logic [TIMER_W-1:0]   duration_q, duration_d;
  logic [MOLE_W-1:0]    molenum_q, molenum_d;
  logic [LVL_W-1:0]     round_level_q, round_level_d;
  logic [HITS_W-1:0]    round_hits_q, round_hits_d;
  logic [SCORE_W-1:0]   total_score_q, total_score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 round_start_q, round_start_d;
  logic                 round_hold_q, round_hold_d;
  logic                 game_win_q, game_win_d;
  logic                 game_over_q, game_over_d;
  logic                 done_lat_q, done_lat_d;

  logic [TIMER_W-1:0]   cfg_interval, cfg_duration;
  logic [MOLE_W-1:0]    cfg_molenum;

  mole_level_cfg #(
    .TIMER_W       (TIMER_W),
    .MOLE_W        (MOLE_W),
    .BASE_INTERVAL (BASE_INTERVAL),
    .STEP_INTERVAL (STEP_INTERVAL),
    .MIN_INTERVAL  (MIN_INTERVAL),
    .BASE_DURATION (BASE_DURATION),
    .STEP_DURATION (STEP_DURATION),
    .MIN_DURATION  (MIN_DURATION),
    .BASE_MOLES    (BASE_MOLES),
    .STEP_MOLES    (STEP_MOLES)
  ) u_level_cfg (
    .level    (round_level_q),
    .interval (cfg_interval),
    .duration (cfg_duration),
    .molenum  (cfg_molenum)
  );

  always_comb begin
    state_d       = state_q;
    interval_d    = interval_q;
    duration_d    = duration_q;
    molenum_d     = molenum_q;
    round_level_d = round_level_q;
    round_hits_d  = round_hits_q;
    total_score_d = total_score_q;
    lives_d       = lives_q;
    done_lat_d    = 1'b0;

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (game_start) begin
          state_d       = S_CONFIG;
          round_level_d = '0;
          round_hits_d  = '0;
          total_score_d = '0;
          lives_d       = LIVES_INIT;
        end
      end
      S_CONFIG: begin
        interval_d   = cfg_interval;
        duration_d   = cfg_duration;
        molenum_d    = cfg_molenum;
        round_hits_d = '0;
        state_d      = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (hit_success) begin
          round_hits_d  = sat_inc_hits(round_hits_q);
          total_score_d = (total_score_q == '1) ? total_score_q
                                                : total_score_q + SCORE_W'(1);
        end
        if (round_done) begin
          state_d = S_EVAL;
        end else if (pause) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        // A round_done seen while paused is remembered until resume.
        if (!pause) begin
          state_d = (done_lat_q || round_done) ? S_EVAL : S_RUNNING;
        end else begin
          done_lat_d = done_lat_q || round_done;
        end
      end
      S_EVAL: begin
        if (round_hits_q >= PASS_C) begin
          if (round_level_q == LAST_LVL) begin
            state_d = S_WIN;
          end else begin
            round_level_d = round_level_q + LVL_W'(1);
            state_d       = S_CONFIG;
          end
        end else begin
          lives_d = lives_q - LIVES_W'(1);
          state_d = (lives_q == LIVES_W'(1)) ? S_LOSE : S_CONFIG;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // round_start trails LAUNCH by one cycle so the config words settle a
    // full cycle before the engine is launched.
    round_start_d = (state_q == S_LAUNCH);
    round_hold_d  = (state_d == S_PAUSED);
    game_win_d    = (state_d == S_WIN);
    game_over_d   = (state_d == S_WIN) || (state_d == S_LOSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      interval_q    <= '0;
      duration_q    <= '0;
      molenum_q     <= '0;
      round_level_q <= '0;
      round_hits_q  <= '0;
      total_score_q <= '0;
      lives_q       <= LIVES_INIT;
      round_start_q <= 1'b0;
      round_hold_q  <= 1'b0;
      game_win_q    <= 1'b0;
      game_over_q   <= 1'b0;
      done_lat_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      interval_q    <= interval_d;
      duration_q    <= duration_d;
      molenum_q     <= molenum_d;
      round_level_q <= round_level_d;
      round_hits_q  <= round_hits_d;
      total_score_q <= total_score_d;
      lives_q       <= lives_d;
      round_start_q <= round_start_d;
      round_hold_q  <= round_hold_d;
      game_win_q    <= game_win_d;
      game_over_q   <= game_over_d;
      done_lat_q    <= done_lat_d;
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_score_q, high_score_d;

  // Score is frozen through EVAL, so total_score_q is final on terminal entry.
  always_comb begin
    high_score_d = high_score_q;
    if (game_over_d && !game_over_q && (total_score_q > high_score_q)) begin
      high_score_d = total_score_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_score_q <= '0;
    end else begin
      high_score_q <= high_score_d;
    end
  end

  assign high_score = high_score_q;
`else
  assign high_score = '0;
`endif

  assign round_start = round_start_q;
  assign interval    = interval_q;
  assign duration    = duration_q;
  assign molenum     = molenum_q;
  assign round_hold  = round_hold_q;
  assign round_level = round_level_q;
  assign round_hits  = round_hits_q;
  assign total_score = total_score_q;
  assign lives       = lives_q;
  assign game_win    = game_win_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: behavioural game model compared
// every cycle, directed scenarios with literal expectations, then random play.
module tb_mole_game_ctrl;

  localparam int NR = 3;
  localparam int PH = 3;
  localparam int ML = 2;
  localparam int TW = 27;
  localparam int MW = 3;
  localparam int SW = 8;
  localparam longint BI = 125000000;
  localparam longint SI = 25000000;
  localparam longint MI = 25000000;
  localparam longint BD = 100000000;
  localparam longint SD = 25000000;
  localparam longint MD = 12500000;
  localparam longint BM = 4;
  localparam longint SM = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          game_start = 1'b0;
  logic          pause = 1'b0;
  logic          hit_success = 1'b0;
  logic          round_done = 1'b0;
  logic          round_start;
  logic [TW-1:0] interval;
  logic [TW-1:0] duration;
  logic [MW-1:0] molenum;
  logic          round_hold;
  logic [2:0]    round_level;
  logic [2:0]    round_hits;
  logic [SW-1:0] total_score;
  logic [2:0]    lives;
  logic          game_win;
  logic          game_over;
  logic [SW-1:0] high_score;

  logic [2:0]    cfg_lvl = 3'd0;
  logic [TW-1:0] c2_iv, c2_du;
  logic [MW-1:0] c2_mn;

  int n_err = 0;
  int n_checks = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  mole_game_ctrl #(
    .NUM_ROUNDS(NR), .PASS_HITS(PH), .MAX_LIVES(ML), .TIMER_W(TW), .MOLE_W(MW),
    .SCORE_W(SW), .BASE_INTERVAL(BI), .STEP_INTERVAL(SI), .MIN_INTERVAL(MI),
    .BASE_DURATION(BD), .STEP_DURATION(SD), .MIN_DURATION(MD),
    .BASE_MOLES(BM), .STEP_MOLES(SM)
  ) u_dut (
    .clk(clk), .rst(rst), .game_start(game_start), .pause(pause),
    .hit_success(hit_success), .round_done(round_done), .round_start(round_start),
    .interval(interval), .duration(duration), .molenum(molenum),
    .round_hold(round_hold), .round_level(round_level), .round_hits(round_hits),
    .total_score(total_score), .lives(lives), .game_win(game_win),
    .game_over(game_over), .high_score(high_score)
  );

  // Steeper configuration to exercise clamping of both interval and molenum.
  mole_level_cfg #(
    .TIMER_W(TW), .MOLE_W(MW), .BASE_INTERVAL(125000000), .STEP_INTERVAL(60000000),
    .MIN_INTERVAL(25000000), .BASE_DURATION(100000000), .STEP_DURATION(25000000),
    .MIN_DURATION(12500000), .BASE_MOLES(6), .STEP_MOLES(1)
  ) u_cfg2 (
    .level(cfg_lvl), .interval(c2_iv), .duration(c2_du), .molenum(c2_mn)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint f_clamp(longint base, longint step, longint fl, int l);
    longint v = base - longint'(l) * step;
    return (v < fl) ? fl : v;
  endfunction

  function automatic longint f_moles(longint base, longint step, int l);
    longint v = base + longint'(l) * step;
    longint mx = (longint'(1) << MW) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- behavioural game model ----------------
  int     m_setup = 0;   // 2: configuring, 1: launching, 0: neither
  bit     m_play = 0, m_pause = 0, m_latch = 0, m_eval = 0;
  int     m_end = 0;     // 0 none, 1 won, 2 lost
  bit     launch_now;
  longint e_iv = 0, e_du = 0, e_mn = 0;
  int     e_lvl = 0, e_hits = 0, e_score = 0, e_lives = ML, e_hs = 0;
  bit     e_start = 0, e_hold = 0, e_win = 0, e_over = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_setup = 0; m_play = 0; m_pause = 0; m_latch = 0; m_eval = 0; m_end = 0;
      e_iv = 0; e_du = 0; e_mn = 0; e_lvl = 0; e_hits = 0; e_score = 0;
      e_lives = ML; e_hs = 0; e_start = 0; e_hold = 0; e_win = 0; e_over = 0;
    end else begin
      launch_now = (m_setup == 1);
      if (m_setup == 2) begin
        e_iv = f_clamp(BI, SI, MI, e_lvl);
        e_du = f_clamp(BD, SD, MD, e_lvl);
        e_mn = f_moles(BM, SM, e_lvl);
        e_hits = 0;
        m_setup = 1;
      end else if (m_setup == 1) begin
        m_setup = 0;
        m_play = 1;
      end else if (m_eval) begin
        m_eval = 0;
        if (e_hits >= PH) begin
          if (e_lvl == NR - 1) m_end = 1;
          else begin e_lvl++; m_setup = 2; end
        end else begin
          e_lives--;
          if (e_lives == 0) m_end = 2;
          else m_setup = 2;
        end
`ifdef HIGH_SCORE_EN
        if (m_end != 0 && e_score > e_hs) e_hs = e_score;
`endif
      end else if (m_play && !m_pause) begin
        if (hit_success) begin
          if (e_hits < 7) e_hits++;
          if (e_score < (1 << SW) - 1) e_score++;
        end
        if (round_done) begin m_play = 0; m_eval = 1; end
        else if (pause) m_pause = 1;
      end else if (m_play) begin
        if (round_done) m_latch = 1;
        if (!pause) begin
          m_pause = 0;
          if (m_latch) begin m_play = 0; m_eval = 1; end
          m_latch = 0;
        end
      end else if (game_start) begin
        m_end = 0; e_lvl = 0; e_hits = 0; e_score = 0; e_lives = ML; m_setup = 2;
      end
      e_start = launch_now;
      e_hold  = m_pause;
      e_win   = (m_end == 1);
      e_over  = (m_end != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("round_start", round_start, e_start);
      chk("interval", interval, e_iv);
      chk("duration", duration, e_du);
      chk("molenum", molenum, e_mn);
      chk("round_hold", round_hold, e_hold);
      chk("round_level", round_level, e_lvl);
      chk("round_hits", round_hits, e_hits);
      chk("total_score", total_score, e_score);
      chk("lives", lives, e_lives);
      chk("game_win", game_win, e_win);
      chk("game_over", game_over, e_over);
      chk("high_score", high_score, e_hs);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    game_start = 1'b1; tick(); game_start = 1'b0;
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (round_start) seen = 1;
      else tick();
    end
    chk("round_start_seen", seen, 1);
  endtask

  task automatic run_round(input int nhits, output longint iv, output longint du,
                           output longint mn);
    wait_start();
    iv = interval; du = duration; mn = molenum;
    for (int i = 0; i < nhits; i++) begin hit_success = 1'b1; tick(); end
    hit_success = 1'b0;
    round_done = 1'b1; tick(); round_done = 1'b0;
  endtask

  longint iv, du, mn;
  longint exp_iv[3] = '{125000000, 100000000, 75000000};
  longint exp_du[3] = '{100000000, 75000000, 50000000};
  longint exp_mn[3] = '{4, 5, 6};
  longint exp_hs;

  initial begin
`ifdef HIGH_SCORE_EN
    exp_hs = 9;
`else
    exp_hs = 0;
`endif
    #1 rst = 1'b0;
    chk_on = 1;
    repeat (3) tick();
    chk("reset_lives", lives, 2);
    chk("reset_round_start", round_start, 0);
    chk("reset_interval", interval, 0);
    chk("reset_score", total_score, 0);
    chk("reset_over", game_over, 0);
    #2 rst = 1'b1;
    tick();

    // Level config clamping on the steeper configuration.
    for (int l = 0; l < 8; l++) begin
      cfg_lvl = 3'(l);
      #1;
      chk("cfg2_interval", c2_iv, f_clamp(125000000, 60000000, 25000000, l));
      chk("cfg2_duration", c2_du, f_clamp(100000000, 25000000, 12500000, l));
      chk("cfg2_molenum", c2_mn, f_moles(6, 1, l));
      if (l == 2) chk("cfg2_iv_l2_floor", c2_iv, 25000000);
      if (l == 1) chk("cfg2_mn_l1_sat", c2_mn, 7);
    end
    tick();

    // Full winning game.
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      run_round(3, iv, du, mn);
      chk("win_cfg_interval", iv, exp_iv[r]);
      chk("win_cfg_duration", du, exp_du[r]);
      chk("win_cfg_molenum", mn, exp_mn[r]);
    end
    tick();
    chk("win_game_win", game_win, 1);
    chk("win_game_over", game_over, 1);
    chk("win_score", total_score, 9);
    chk("win_lives", lives, 2);

    // Two failed rounds at level 0: retry then lose.
    pulse_start();
    run_round(2, iv, du, mn);
    tick();
    chk("fail1_lives", lives, 1);
    chk("fail1_level", round_level, 0);
    run_round(2, iv, du, mn);
    chk("retry_interval", iv, 125000000);
    chk("retry_molenum", mn, 4);
    tick();
    chk("lose_over", game_over, 1);
    chk("lose_win", game_win, 0);
    chk("lose_lives", lives, 0);
    chk("lose_score", total_score, 4);
    chk("high_score_kept", high_score, exp_hs);

    // Pause with hit and round_done arriving while paused.
    pulse_start();
    wait_start();
    hit_success = 1'b1; tick(); hit_success = 1'b0;
    pause = 1'b1; tick(); tick();
    chk("pause_hold", round_hold, 1);
    hit_success = 1'b1; round_done = 1'b1; tick();
    hit_success = 1'b0; round_done = 1'b0; tick();
    chk("pause_hits_frozen", round_hits, 1);
    chk("pause_hold_still", round_hold, 1);
    pause = 1'b0; tick();
    chk("resume_hold_off", round_hold, 0);
    tick();
    chk("resume_eval_lives", lives, 1);

    // Reset in the middle of the retry round.
    wait_start();
    hit_success = 1'b1; tick(); hit_success = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("midrst_round_start", round_start, 0);
    chk("midrst_interval", interval, 0);
    chk("midrst_level", round_level, 0);
    chk("midrst_score", total_score, 0);
    chk("midrst_lives", lives, 2);
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_round_start", round_start, 0);
    end

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        tick();
        #2 rst = 1'b1;
      end
      game_start  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      hit_success = ($urandom_range(0, 2) == 0);
      round_done  = ($urandom_range(0, 9) == 0);
    end
    game_start = 1'b0; pause = 1'b0; hit_success = 1'b0; round_done = 1'b0;
    repeat (3) tick();
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
